pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Control-side driver of the program counter: generates FETCH/CK/LD/LATCH strobes and PC load value.
//  Fetches each instruction from memory at the latched PC and resolves JMP, JMS and skip locally.
//  Hands every other instruction to execute logic via ir_valid/exec_done.
//  Sits between program counter, memory port and instruction execute logic.
// PARAMETERS
//  GAP_CYCLES  1  idle cycles (>=1) after every PC strobe, before the next strobe or any use of pc_lat
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset, synchronous, active-high
//  run        in   1   level; start/continue instruction cycles
//  halt_req   in   1   level; stop at next instruction boundary
//  pc_lat     in   12  latched PC from program counter
//  skip_cond  in   1   group-2 operate skip condition, valid while ir_valid high
//  exec_done  in   1   execute logic finished current instruction
//  mem_ack    in   1   memory completed request this cycle
//  mem_rdata  in   12  read data, valid with mem_ack
//  pc_in      out  12  PC load value
//  pc_ld      out  1   PC load strobe
//  pc_ck      out  1   PC increment strobe
//  pc_latch   out  1   copy PC to PCLAT along with pc_ck
//  pc_fetch   out  1   fetch strobe (PCLAT<=PC, PC<=PC+1)
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   write qualifier for mem_req
//  mem_addr   out  12  memory address
//  mem_wdata  out  12  write data
//  ir         out  12  current instruction
//  ir_valid   out  1   high while execute logic owns ir
//  running    out  1   high outside IDLE/HALT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, gap counter 0. Reset overrides any state, incl. open mem_req.
//  Strobe rules:
//   - Each pc_fetch/pc_ld/pc_ck is exactly one cycle high, at most one per cycle.
//   - Each is followed by GAP_CYCLES cycles with all strobes low.
//   - pc_ck never in the cycle after pc_fetch (guaranteed by the gap).
//  States:
//   IDLE   : run & !halt_req -> FETCH.
//   FETCH  : pc_fetch=1 for one cycle -> GAP -> READ.
//   READ   : mem_req=1, we=0, addr=pc_lat, held stable until mem_ack. On ack: ir<=mem_rdata -> DECODE.
//   DECODE : op=ir[11:9]; EA={ir[7]?pc_lat[11:7]:5'b0, ir[6:0]}.
//            op 4/5 & ir[8] -> DEFER. op 4 -> JMSW. op 5 -> JUMP. Otherwise -> EXEC.
//   DEFER  : read at EA; on ack EA<=mem_rdata, then JMSW/JUMP per op. No auto-index handling.
//   JMSW   : write mem_addr=EA, wdata=pc_lat+1 (12-bit wrap, 7777->0000) -> JUMP.
//   JUMP   : pc_in=EA, pc_ld one cycle -> GAP.
//            op 5 then goes to NEXT. op 4 then goes to SKIP, giving PC=EA+1.
//   EXEC   : ir_valid=1.
//            op 7 & ir[8] & !ir[0] & skip_cond sampled in first EXEC cycle sets a skip flag.
//            Stay until exec_done. Then ir_valid=0 -> SKIP if flag set, else NEXT.
//   SKIP   : pc_ck one cycle, pc_latch=0 -> GAP -> NEXT.
//   NEXT   : halt_req | !run -> HALT, else FETCH.
//   HALT   : running=0; run & !halt_req -> FETCH.
//  Edge cases:
//   - halt_req mid-instruction completes the instruction first.
//   - mem_ack in the same cycle that mem_req rises is accepted.
//   - exec_done ignored outside EXEC.
//   - pc_in holds its last value when pc_ld is low.
//  Latency (mem_ack same cycle, GAP_CYCLES=1):
//   - plain instruction fetch-to-ir_valid = 4 cycles;
//   - JMP direct fetch-to-next-pc_fetch = 7 cycles.
// TESTING
//  1 reset, PC=0200, mem[0200]=7000 (NOP), run=1, exec_done 1 cycle later
//    -> pc_fetch, gap, READ @0200, ir=7000, ir_valid, next pc_fetch; never two strobes adjacent.
//  2 pc_lat=0200, mem[0200]=5377 (JMP current page)
//    -> pc_ld with pc_in=0377, no pc_ck, next fetch reads 0377.
//  3 pc_lat=0300, mem[0300]=4410 (JMS I 0010), mem[0010]=1234
//    -> write 0301 to 1234, pc_ld pc_in=1234, then pc_ck one cycle.
//  4 mem[0200]=7450 (SNA), skip_cond=1 -> one pc_ck after exec_done;
//    same instruction with skip_cond=0 -> no pc_ck.
//  5 mem_ack delayed 5 cycles; reset asserted during READ
//    -> mem_addr stable while waiting; reset clears mem_req and all outputs next cycle.
//  6 halt_req raised during EXEC -> instruction completes, HALT, running=0;
//    pc_lat=7777 JMS path -> wdata=0000.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Signal bundle between pc_sequencer (master) and the program counter,
// memory port and execute logic it drives (slave).
interface pc_sequencer_if;
  logic        run;
  logic        halt_req;
  logic [11:0] pc_lat;
  logic        skip_cond;
  logic        exec_done;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic [11:0] pc_in;
  logic        pc_ld;
  logic        pc_ck;
  logic        pc_latch;
  logic        pc_fetch;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] ir;
  logic        ir_valid;
  logic        running;

  modport master (
    input  run, halt_req, pc_lat, skip_cond, exec_done, mem_ack, mem_rdata,
    output pc_in, pc_ld, pc_ck, pc_latch, pc_fetch, mem_req, mem_we,
           mem_addr, mem_wdata, ir, ir_valid, running
  );

  modport slave (
    output run, halt_req, pc_lat, skip_cond, exec_done, mem_ack, mem_rdata,
    input  pc_in, pc_ld, pc_ck, pc_latch, pc_fetch, mem_req, mem_we,
           mem_addr, mem_wdata, ir, ir_valid, running
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-cycle sequencer: strobes the program counter, fetches each
// instruction, resolves JMP/JMS/skip locally and hands the rest to execute logic.
module pc_sequencer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  localparam int            GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_GAP, S_READ, S_DECODE, S_DEFER,
    S_JMSW, S_JUMP, S_EXEC, S_SKIP, S_NEXT, S_HALT
  } state_t;

  state_t          state, state_nx;
  state_t          gap_ret, gap_ret_nx;
  logic [GW-1:0]   gap_cnt;
  logic [11:0]     ir_q, ea, pc_in_q;
  logic            skip_flag, exec_first;

  logic            fetch_o, ld_o, ck_o, req_o, we_o, ir_valid_o;
  logic [11:0]     addr_o, wdata_o, pc_in_o;

  logic [2:0]      op;
  logic            skip_hit, skip_now;
  logic [11:0]     ea_dir;

  assign op       = ir_q[11:9];
  assign ea_dir   = {ir_q[7] ? bus.pc_lat[11:7] : 5'b0, ir_q[6:0]};
  assign skip_hit = (op == 3'd7) && ir_q[8] && !ir_q[0] && bus.skip_cond;
  // The first EXEC cycle has not registered the flag yet, so use it directly.
  assign skip_now = exec_first ? skip_hit : skip_flag;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      gap_ret <= S_IDLE;
    end else begin
      state   <= state_nx;
      gap_ret <= gap_ret_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt    <= '0;
      ir_q       <= '0;
      ea         <= '0;
      pc_in_q    <= '0;
      skip_flag  <= 1'b0;
      exec_first <= 1'b0;
    end else begin
      if (fetch_o || ld_o || ck_o)
        gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
      if (state == S_READ && bus.mem_ack)
        ir_q <= bus.mem_rdata;
      if (state == S_DECODE)
        ea <= ea_dir;
      else if (state == S_DEFER && bus.mem_ack)
        ea <= bus.mem_rdata;
      if (state == S_JUMP)
        pc_in_q <= ea;
      exec_first <= (state == S_DECODE) && (state_nx == S_EXEC);
      if (state == S_EXEC && exec_first)
        skip_flag <= skip_hit;
    end
  end

  // NOTE: every value driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    gap_ret_nx = gap_ret;
    fetch_o    = 1'b0;
    ld_o       = 1'b0;
    ck_o       = 1'b0;
    req_o      = 1'b0;
    we_o       = 1'b0;
    addr_o     = '0;
    wdata_o    = '0;
    ir_valid_o = 1'b0;
    pc_in_o    = pc_in_q;
    case (state)
      S_IDLE, S_HALT: if (bus.run && !bus.halt_req) state_nx = S_FETCH;
      S_FETCH: begin
        fetch_o    = 1'b1;
        state_nx   = S_GAP;
        gap_ret_nx = S_READ;
      end
      S_GAP: if (gap_cnt == '0) state_nx = gap_ret;
      S_READ: begin
        req_o  = 1'b1;
        addr_o = bus.pc_lat;
        if (bus.mem_ack) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if ((op == 3'd4 || op == 3'd5) && ir_q[8]) state_nx = S_DEFER;
        else if (op == 3'd4)                       state_nx = S_JMSW;
        else if (op == 3'd5)                       state_nx = S_JUMP;
        else                                       state_nx = S_EXEC;
      end
      S_DEFER: begin
        req_o  = 1'b1;
        addr_o = ea;
        if (bus.mem_ack) state_nx = (op == 3'd4) ? S_JMSW : S_JUMP;
      end
      S_JMSW: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = ea;
        wdata_o = bus.pc_lat + 12'd1;
        if (bus.mem_ack) state_nx = S_JUMP;
      end
      S_JUMP: begin
        ld_o       = 1'b1;
        pc_in_o    = ea;
        state_nx   = S_GAP;
        // JMS lands on EA+1: the subroutine body follows the return-address word.
        gap_ret_nx = (op == 3'd4) ? S_SKIP : S_NEXT;
      end
      S_EXEC: begin
        ir_valid_o = 1'b1;
        if (bus.exec_done) state_nx = skip_now ? S_SKIP : S_NEXT;
      end
      S_SKIP: begin
        ck_o       = 1'b1;
        state_nx   = S_GAP;
        gap_ret_nx = S_NEXT;
      end
      S_NEXT: state_nx = (bus.halt_req || !bus.run) ? S_HALT : S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.pc_fetch  = fetch_o;
  assign bus.pc_ld     = ld_o;
  assign bus.pc_ck     = ck_o;
  assign bus.pc_latch  = 1'b0;
  assign bus.pc_in     = pc_in_o;
  assign bus.mem_req   = req_o;
  assign bus.mem_we    = we_o;
  assign bus.mem_addr  = addr_o;
  assign bus.mem_wdata = wdata_o;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_o;
  assign bus.running   = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: PC, memory and execute models around the DUT; observed
// strobes and bus transactions are matched in order against an expected queue.
module tb_pc_sequencer;
  localparam int GAP = 1;

  typedef enum logic [2:0] {EV_NONE = 3'd0, EV_FETCH, EV_RD, EV_WR, EV_LD, EV_CK, EV_IR} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [11:0] a;
    logic [11:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();
  pc_sequencer #(.GAP_CYCLES(GAP)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [11:0] mem [4096];
  int          ack_delay, exec_delay;
  int          wait_cnt = 0;
  int          ex_cnt = 0;
  logic [11:0] pc_m, pc_lat_m, pc_set_val;
  logic        pc_set;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  vectors = 0;
  int  misc = 0;
  int  cyc = 0, last_fetch = 0, lat_ir = 0, lat_ff = 0, since = GAP, viol = 0;
  logic ivp = 1'b0;

  assign bus.pc_lat    = pc_lat_m;
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
  assign bus.exec_done = bus.ir_valid && (ex_cnt >= exec_delay);

  // Program counter, memory wait-state and execute-duration models.
  always @(posedge clk) begin
    if (pc_set) begin
      pc_m     <= pc_set_val;
      pc_lat_m <= pc_set_val;
    end else if (bus.pc_fetch) begin
      pc_lat_m <= pc_m;
      pc_m     <= pc_m + 12'd1;
    end else if (bus.pc_ld) begin
      pc_m <= bus.pc_in;
    end else if (bus.pc_ck) begin
      pc_m <= pc_m + 12'd1;
    end
    wait_cnt <= (reset || !bus.mem_req || bus.mem_ack) ? 0 : wait_cnt + 1;
    ex_cnt   <= (reset || !bus.ir_valid) ? 0 : ex_cnt + 1;
  end

  function automatic ev_t mk(input ev_kind_t k, input logic [11:0] a, input logic [11:0] d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    return e;
  endfunction

  // Monitor: records observed events and strobe-spacing violations mid-cycle.
  initial begin
    forever begin
      int n;
      @(negedge clk);
      cyc++;
      if (reset) begin
        since = GAP;
        ivp   = 1'b0;
      end else begin
        n = int'(bus.pc_fetch) + int'(bus.pc_ld) + int'(bus.pc_ck);
        if (n > 1) viol++;
        if (n > 0 && since < GAP) viol++;
        since = (n > 0) ? 0 : ((since < 1000) ? since + 1 : since);
        if (bus.pc_fetch) begin
          lat_ff     = cyc - last_fetch;
          last_fetch = cyc;
          obs_q.push_back(mk(EV_FETCH, pc_m, 12'd0));
        end
        if (bus.mem_req && bus.mem_ack)
          obs_q.push_back(mk(bus.mem_we ? EV_WR : EV_RD, bus.mem_addr,
                             bus.mem_we ? bus.mem_wdata : bus.mem_rdata));
        if (bus.pc_ld) obs_q.push_back(mk(EV_LD, bus.pc_in, 12'd0));
        if (bus.pc_ck) obs_q.push_back(mk(EV_CK, 12'd0, 12'd0));
        if (bus.ir_valid && !ivp) begin
          lat_ir = cyc - last_fetch;
          obs_q.push_back(mk(EV_IR, 12'd0, bus.ir));
        end
        ivp = bus.ir_valid;
      end
    end
  end

  task automatic apply_reset(input logic [11:0] pc0);
    @(negedge clk);
    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.halt_req = 1'b0;
    bus.skip_cond = 1'b0;
    pc_set       = 1'b1;
    pc_set_val   = pc0;
    ack_delay    = 0;
    exec_delay   = 1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    pc_set = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [7:0]  s;
    logic [47:0] w;
    apply_reset(12'o0200);
    repeat (3) @(negedge clk);
    s = {bus.pc_fetch, bus.pc_ld, bus.pc_ck, bus.pc_latch, bus.mem_req, bus.mem_we, bus.ir_valid, bus.running};
    w = {bus.mem_addr, bus.mem_wdata, bus.ir, bus.pc_in};
    vectors++;
    if (s !== 8'h00) begin misc++; $display("FAIL reset_ctrl: got %b expected 00000000", s); end
    vectors++;
    if (w !== 48'h0) begin misc++; $display("FAIL reset_data: got %h expected 0", w); end
  endtask

  task automatic test_nop();
    ev_t e, o;
    int  v0;
    apply_reset(12'o0200);
    mem[12'o0200] = 12'o7000;
    v0 = viol;
    exp_q.push_back(mk(EV_FETCH, 12'o0200, 12'o0000));
    exp_q.push_back(mk(EV_RD,    12'o0200, 12'o7000));
    exp_q.push_back(mk(EV_IR,    12'o0000, 12'o7000));
    exp_q.push_back(mk(EV_FETCH, 12'o0201, 12'o0000));
    bus.run = 1'b1;
    wait_obs(4, 60);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      vectors++;
      if (o !== e) begin
        misc++;
        $display("FAIL nop_seq: got %s %o/%o expected %s %o/%o", o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
      end
    end
    vectors++;
    if (lat_ir !== 4) begin misc++; $display("FAIL nop_latency: got %0d expected 4", lat_ir); end
    vectors++;
    if (viol !== v0) begin misc++; $display("FAIL nop_strobe_gap: got %0d violations expected 0", viol - v0); end
    bus.run = 1'b0;
  endtask

  task automatic test_jmp();
    ev_t e, o;
    apply_reset(12'o0200);
    mem[12'o0200] = 12'o5377;
    exp_q.push_back(mk(EV_FETCH, 12'o0200, 12'o0000));
    exp_q.push_back(mk(EV_RD,    12'o0200, 12'o5377));
    exp_q.push_back(mk(EV_LD,    12'o0377, 12'o0000));
    exp_q.push_back(mk(EV_FETCH, 12'o0377, 12'o0000));
    exp_q.push_back(mk(EV_RD,    12'o0377, 12'o7000));
    bus.run = 1'b1;
    wait_obs(5, 60);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      vectors++;
      if (o !== e) begin
        misc++;
        $display("FAIL jmp_seq: got %s %o/%o expected %s %o/%o", o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
      end
    end
    vectors++;
    if (lat_ff !== 7) begin misc++; $display("FAIL jmp_latency: got %0d expected 7", lat_ff); end
    bus.run = 1'b0;
  endtask

  task automatic test_jms_indirect();
    ev_t e, o;
    int  v0;
    apply_reset(12'o0300);
    mem[12'o0300] = 12'o4410;
    mem[12'o0010] = 12'o1234;
    v0 = viol;
    exp_q.push_back(mk(EV_FETCH, 12'o0300, 12'o0000));
    exp_q.push_back(mk(EV_RD,    12'o0300, 12'o4410));
    exp_q.push_back(mk(EV_RD,    12'o0010, 12'o1234));
    exp_q.push_back(mk(EV_WR,    12'o1234, 12'o0301));
    exp_q.push_back(mk(EV_LD,    12'o1234, 12'o0000));
    exp_q.push_back(mk(EV_CK,    12'o0000, 12'o0000));
    exp_q.push_back(mk(EV_FETCH, 12'o1235, 12'o0000));
    bus.run = 1'b1;
    wait_obs(7, 80);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      vectors++;
      if (o !== e) begin
        misc++;
        $display("FAIL jms_seq: got %s %o/%o expected %s %o/%o", o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
      end
    end
    vectors++;
    if (viol !== v0) begin misc++; $display("FAIL jms_strobe_gap: got %0d violations expected 0", viol - v0); end
    bus.run = 1'b0;
  endtask

  task automatic test_skip();
    ev_t e, o;
    for (int sc = 1; sc >= 0; sc--) begin
      apply_reset(12'o0200);
      mem[12'o0200] = 12'o7450;
      bus.skip_cond = sc[0];
      exp_q.push_back(mk(EV_FETCH, 12'o0200, 12'o0000));
      exp_q.push_back(mk(EV_RD,    12'o0200, 12'o7450));
      exp_q.push_back(mk(EV_IR,    12'o0000, 12'o7450));
      if (sc == 1) exp_q.push_back(mk(EV_CK, 12'o0000, 12'o0000));
      exp_q.push_back(mk(EV_FETCH, (sc == 1) ? 12'o0202 : 12'o0201, 12'o0000));
      bus.run = 1'b1;
      wait_obs(exp_q.size(), 60);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
        vectors++;
        if (o !== e) begin
          misc++;
          $display("FAIL skip_seq(cond=%0d): got %s %o/%o expected %s %o/%o", sc, o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
        end
      end
      bus.run = 1'b0;
    end
  endtask

  task automatic test_ack_delay_reset();
    ev_t  e, o;
    int   n;
    logic stable;
    logic [7:0]  s;
    logic [47:0] w;
    apply_reset(12'o0200);
    mem[12'o0200] = 12'o7000;
    ack_delay = 5;
    exp_q.push_back(mk(EV_FETCH, 12'o0200, 12'o0000));
    exp_q.push_back(mk(EV_RD,    12'o0200, 12'o7000));
    exp_q.push_back(mk(EV_IR,    12'o0000, 12'o7000));
    bus.run = 1'b1;
    for (int i = 0; i < 20 && bus.mem_req !== 1'b1; i++) @(negedge clk);
    n = 0;
    stable = 1'b1;
    while (bus.mem_ack !== 1'b1 && n < 20) begin
      if (bus.mem_addr !== 12'o0200 || bus.mem_req !== 1'b1) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (stable !== 1'b1) begin misc++; $display("FAIL wait_addr_stable: got changed expected held at 0200"); end
    vectors++;
    if (n !== 5) begin misc++; $display("FAIL wait_cycles: got %0d expected 5", n); end
    wait_obs(3, 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      vectors++;
      if (o !== e) begin
        misc++;
        $display("FAIL delayed_seq: got %s %o/%o expected %s %o/%o", o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
      end
    end
    // Next READ never gets acked; reset lands while it is open.
    ack_delay = 1000;
    @(negedge clk);
    for (int i = 0; i < 30 && bus.mem_req !== 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.ir !== 12'o7000) begin
      misc++;
      $display("FAIL pre_reset_read: got req=%b ir=%o expected req=1 ir=7000", bus.mem_req, bus.ir);
    end
    reset = 1'b1;
    @(negedge clk);
    s = {bus.pc_fetch, bus.pc_ld, bus.pc_ck, bus.pc_latch, bus.mem_req, bus.mem_we, bus.ir_valid, bus.running};
    w = {bus.mem_addr, bus.mem_wdata, bus.ir, bus.pc_in};
    vectors++;
    if (s !== 8'h00) begin misc++; $display("FAIL midread_reset_ctrl: got %b expected 00000000", s); end
    vectors++;
    if (w !== 48'h0) begin misc++; $display("FAIL midread_reset_data: got %h expected 0", w); end
    reset   = 1'b0;
    bus.run = 1'b0;
    ack_delay = 0;
  endtask

  task automatic test_halt();
    ev_t e, o;
    apply_reset(12'o0200);
    mem[12'o0200] = 12'o7000;
    exec_delay = 3;
    exp_q.push_back(mk(EV_FETCH, 12'o0200, 12'o0000));
    exp_q.push_back(mk(EV_RD,    12'o0200, 12'o7000));
    exp_q.push_back(mk(EV_IR,    12'o0000, 12'o7000));
    bus.run = 1'b1;
    for (int i = 0; i < 30 && bus.ir_valid !== 1'b1; i++) @(negedge clk);
    bus.halt_req = 1'b1;
    for (int i = 0; i < 40 && bus.running !== 1'b0; i++) @(negedge clk);
    vectors++;
    if (bus.running !== 1'b0 || bus.ir_valid !== 1'b0) begin
      misc++;
      $display("FAIL halt_state: got running=%b ir_valid=%b expected 0/0", bus.running, bus.ir_valid);
    end
    repeat (10) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      vectors++;
      if (o !== e) begin
        misc++;
        $display("FAIL halt_seq: got %s %o/%o expected %s %o/%o", o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
      end
    end
    vectors++;
    if (obs_q.size() !== 0) begin misc++; $display("FAIL halt_quiet: got %0d events expected 0", obs_q.size()); end
    exp_q.push_back(mk(EV_FETCH, 12'o0201, 12'o0000));
    bus.halt_req = 1'b0;
    wait_obs(1, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      vectors++;
      if (o !== e) begin
        misc++;
        $display("FAIL resume_seq: got %s %o/%o expected %s %o/%o", o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
      end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_jms_wrap();
    ev_t e, o;
    apply_reset(12'o7777);
    mem[12'o7777] = 12'o4020;
    exp_q.push_back(mk(EV_FETCH, 12'o7777, 12'o0000));
    exp_q.push_back(mk(EV_RD,    12'o7777, 12'o4020));
    exp_q.push_back(mk(EV_WR,    12'o0020, 12'o0000));
    exp_q.push_back(mk(EV_LD,    12'o0020, 12'o0000));
    exp_q.push_back(mk(EV_CK,    12'o0000, 12'o0000));
    exp_q.push_back(mk(EV_FETCH, 12'o0021, 12'o0000));
    bus.run = 1'b1;
    wait_obs(6, 80);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      vectors++;
      if (o !== e) begin
        misc++;
        $display("FAIL jms_wrap_seq: got %s %o/%o expected %s %o/%o", o.kind.name(), o.a, o.d, e.kind.name(), e.a, e.d);
      end
    end
    bus.run = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.halt_req  = 1'b0;
    bus.skip_cond = 1'b0;
    pc_set        = 1'b1;
    pc_set_val    = 12'o0200;
    ack_delay     = 0;
    exec_delay    = 1;
    for (int i = 0; i < 4096; i++) mem[i] = 12'o7000;
    test_reset();
    test_nop();
    test_jmp();
    test_jms_indirect();
    test_skip();
    test_ack_delay_reset();
    test_halt();
    test_jms_wrap();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule
